// File: rtl/hi_ssp_link_if.sv
// Bundles the TX/RX word handshakes and the SSP pins of hi_ssp_link.
// The link master (mode-block side and ARM pins) drives; the SSP core is the slave.
interface hi_ssp_link_if #(
  parameter int unsigned WORD_BITS = 8,
  parameter int unsigned TX_DEPTH  = 4
);
  localparam int unsigned LVL_W = $clog2(TX_DEPTH) + 1;

  logic                 en;
  logic [WORD_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [LVL_W-1:0]     tx_level;
  logic                 tx_underrun;
  logic                 clr_underrun;
  logic [WORD_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 ssp_clk;
  logic                 ssp_frame;
  logic                 ssp_din;
  logic                 ssp_dout;

  modport master (
    output en, tx_data, tx_valid, clr_underrun, ssp_dout,
    input  tx_ready, tx_level, tx_underrun, rx_data, rx_valid,
           ssp_clk, ssp_frame, ssp_din
  );

  modport slave (
    input  en, tx_data, tx_valid, clr_underrun, ssp_dout,
    output tx_ready, tx_level, tx_underrun, rx_data, rx_valid,
           ssp_clk, ssp_frame, ssp_din
  );
endinterface

// File: rtl/hi_ssp_link.sv
// SSP master between the FPGA mode blocks and the ARM: buffered MSB-first TX
// serialiser with idle fill and sticky underrun, plus an RX deserialiser.
module hi_ssp_link #(
  parameter int unsigned          WORD_BITS = 8,
  parameter int unsigned          CLK_DIV   = 4,
  parameter int unsigned          TX_DEPTH  = 4,
  parameter logic [WORD_BITS-1:0] IDLE_WORD = '0
) (
  input  logic          ck_1356meg,
  input  logic          rst_n,
  hi_ssp_link_if.slave  link
);
  localparam int unsigned HALF  = CLK_DIV / 2;
  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned BIT_W = $clog2(WORD_BITS);
  localparam int unsigned PTR_W = $clog2(TX_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [BIT_W-1:0]     bit_q, bit_next_c;
  logic                 first_q;
  logic                 fall_c, wrap_c, stop_c;
  logic                 load_c, push_c, pop_c, under_set_c;
  logic [WORD_BITS-1:0] load_word_c, tx_sh_q, rx_word_c;
  logic [WORD_BITS-2:0] rx_sh_q;
  logic [WORD_BITS-1:0] mem [TX_DEPTH];
  logic [PTR_W-1:0]     wr_q, rd_q;
  logic [LVL_W-1:0]     count_q, count_d;
  logic                 ready_q, under_q, clk_q, frame_q, din_q, rx_valid_q;
  logic [WORD_BITS-1:0] rx_data_q;

  always_ff @(posedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Sequencing: divider phase events; en is only honoured at the word boundary.
  always_comb begin
    state_d = state_q;
    div_d   = '0;
    fall_c  = 1'b0;
    wrap_c  = 1'b0;
    stop_c  = 1'b0;
    case (state_q)
      S_IDLE: if (link.en) state_d = S_RUN;
      S_RUN: begin
        div_d = div_q + 1'b1;
        if (div_q == DIV_W'(HALF - 1)) begin
          if (bit_q == BIT_W'(WORD_BITS - 1) && !link.en) begin
            state_d = S_IDLE;
            stop_c  = 1'b1;
            div_d   = '0;
          end else begin
            fall_c = 1'b1;
          end
        end
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          wrap_c = 1'b1;
          div_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The first falling event after start keeps bit 0 so it loads a word.
  always_comb begin
    bit_next_c  = '0;
    if (!first_q && bit_q != BIT_W'(WORD_BITS - 1)) bit_next_c = bit_q + 1'b1;
    load_c      = fall_c && (bit_next_c == '0);
    pop_c       = load_c && (count_q != '0);
    under_set_c = load_c && (count_q == '0);
    push_c      = link.tx_valid && ready_q;
    load_word_c = pop_c ? mem[rd_q] : IDLE_WORD;
    rx_word_c   = {rx_sh_q, link.ssp_dout};
    count_d     = count_q;
    if (push_c && !pop_c)      count_d = count_q + 1'b1;
    else if (pop_c && !push_c) count_d = count_q - 1'b1;
  end

  always_ff @(posedge ck_1356meg) begin
    if (push_c) mem[wr_q] <= link.tx_data;
  end

  always_ff @(posedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      bit_q      <= '0;
      first_q    <= 1'b1;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      ready_q    <= 1'b1;
      under_q    <= 1'b0;
      clk_q      <= 1'b0;
      frame_q    <= 1'b0;
      din_q      <= 1'b0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      clk_q      <= (state_d == S_RUN) && (div_d < DIV_W'(HALF));
      rx_valid_q <= 1'b0;
      count_q    <= count_d;
      ready_q    <= (count_d != LVL_W'(TX_DEPTH));
      if (push_c) wr_q <= wr_q + 1'b1;
      if (pop_c)  rd_q <= rd_q + 1'b1;
      if (under_set_c)            under_q <= 1'b1;
      else if (link.clr_underrun) under_q <= 1'b0;
      if (stop_c) begin
        bit_q   <= '0;
        first_q <= 1'b1;
        frame_q <= 1'b0;
      end
      if (fall_c) begin
        bit_q   <= bit_next_c;
        first_q <= 1'b0;
        frame_q <= load_c;
        if (load_c) begin
          din_q   <= load_word_c[WORD_BITS-1];
          tx_sh_q <= load_word_c << 1;
        end else begin
          din_q   <= tx_sh_q[WORD_BITS-1];
          tx_sh_q <= tx_sh_q << 1;
        end
      end
      if (wrap_c) begin
        rx_sh_q <= rx_word_c[WORD_BITS-2:0];
        if (bit_q == BIT_W'(WORD_BITS - 1)) begin
          rx_data_q  <= rx_word_c;
          rx_valid_q <= 1'b1;
        end
      end
    end
  end

  assign link.tx_ready    = ready_q;
  assign link.tx_level    = count_q;
  assign link.tx_underrun = under_q;
  assign link.rx_data     = rx_data_q;
  assign link.rx_valid    = rx_valid_q;
  assign link.ssp_clk     = clk_q;
  assign link.ssp_frame   = frame_q;
  assign link.ssp_din     = din_q;
endmodule

// File: tb/tb_hi_ssp_link.sv
// Scoreboard bench for hi_ssp_link in loopback: a queue model of the TX FIFO
// predicts the framed word stream; a monitor decodes the SSP pins and rx strobes.
module tb_hi_ssp_link;
  localparam int unsigned W     = 8;
  localparam int unsigned DIV   = 4;
  localparam int unsigned DEPTH = 4;
  localparam logic [7:0]  IDLE  = 8'h00;

  logic ck    = 1'b0;
  logic rst_n = 1'b1;

  hi_ssp_link_if #(.WORD_BITS(W), .TX_DEPTH(DEPTH)) link();

  hi_ssp_link #(
    .WORD_BITS(W), .CLK_DIV(DIV), .TX_DEPTH(DEPTH), .IDLE_WORD(IDLE)
  ) dut (
    .ck_1356meg(ck),
    .rst_n     (rst_n),
    .link      (link)
  );

  always #5 ck = ~ck;
  assign link.ssp_dout = link.ssp_din;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  logic [7:0] model[$];
  bit         exp_under = 1'b0;

  int         cyc = 0, n_rxv = 0, rx_t_last = 0, rx_t_prev = 0;
  int         mon_nb = 0, mon_flen = 0, mon_last_rise = 0;
  logic [7:0] mon_sh = '0;
  logic       mon_prev_clk = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: decode words as the ARM would (sample ssp_din on ssp_clk rise).
  always @(negedge ck) begin
    cyc++;
    if (!rst_n) begin
      mon_nb = 0; mon_flen = 0; mon_prev_clk = 1'b0;
    end else begin
      if (link.ssp_frame) mon_flen++;
      else if (mon_flen != 0) begin
        check("frame_width", mon_flen, DIV);
        mon_flen = 0;
      end
      if (link.ssp_clk && !mon_prev_clk) begin
        if (!link.ssp_frame && mon_nb > 0) check("sspclk_period", cyc - mon_last_rise, DIV);
        mon_last_rise = cyc;
        if (link.ssp_frame) begin
          mon_sh = {7'b0, link.ssp_din};
          mon_nb = 1;
        end else if (mon_nb > 0) begin
          mon_sh = {mon_sh[6:0], link.ssp_din};
          mon_nb++;
        end
        if (mon_nb == W) begin
          if (exp_tx.size() == 0) check("tx_unexpected_word", 1, 0);
          else                    check("tx_word", mon_sh, exp_tx.pop_front());
          mon_nb = 0;
        end
      end
      mon_prev_clk = link.ssp_clk;
      if (link.rx_valid) begin
        n_rxv++;
        rx_t_prev = rx_t_last;
        rx_t_last = cyc;
        if (exp_rx.size() == 0) check("rx_unexpected", 1, 0);
        else                    check("rx_data", link.rx_data, exp_rx.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge ck); #1;
  endtask

  task automatic push_one(input logic [7:0] w);
    link.tx_data  = w;
    link.tx_valid = 1'b1;
    tick();
    if (model.size() < DEPTH) model.push_back(w);
    check("tx_level", link.tx_level, model.size());
    check("tx_ready", link.tx_ready, model.size() < DEPTH);
  endtask

  task automatic plan_words(input int k);
    for (int i = 0; i < k; i++) begin
      logic [7:0] w;
      if (model.size() > 0) w = model.pop_front();
      else begin
        w = IDLE;
        exp_under = 1'b1;
      end
      exp_tx.push_back(w);
      exp_rx.push_back(w);
    end
  endtask

  task automatic wait_frame();
    bit ok = 1'b0;
    logic last = link.ssp_frame;
    for (int i = 0; i < 200; i++) begin
      @(negedge ck);
      if (link.ssp_frame && !last) begin
        ok = 1'b1;
        break;
      end
      last = link.ssp_frame;
    end
    if (!ok) check("frame_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int  t = 0;
    bit  seen = 1'b0;
    while ((exp_tx.size() != 0 || exp_rx.size() != 0) && t < 600) begin
      @(negedge ck);
      t++;
    end
    if (t >= 600) begin
      check("drain_timeout", exp_tx.size() + exp_rx.size(), 0);
      exp_tx.delete();
      exp_rx.delete();
    end
    repeat (4) @(negedge ck);
    repeat (8) begin
      @(negedge ck);
      if (link.ssp_clk) seen = 1'b1;
    end
    check("sspclk_stopped", seen, 0);
  endtask

  task automatic run_words(input int k);
    plan_words(k);
    tick();
    link.en = 1'b1;
    for (int i = 0; i < k; i++) wait_frame();
    link.en = 1'b0;
    wait_idle();
    check("underrun_after_run", link.tx_underrun, exp_under);
    check("level_after_run", link.tx_level, model.size());
  endtask

  task automatic clr_pulse();
    tick();
    link.clr_underrun = 1'b1;
    tick();
    link.clr_underrun = 1'b0;
    exp_under = 1'b0;
    check("underrun_clear", link.tx_underrun, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ssp_clk"},   link.ssp_clk, 0);
    check({tag, "_ssp_frame"}, link.ssp_frame, 0);
    check({tag, "_ssp_din"},   link.ssp_din, 0);
    check({tag, "_rx_data"},   link.rx_data, 0);
    check({tag, "_rx_valid"},  link.rx_valid, 0);
    check({tag, "_underrun"},  link.tx_underrun, 0);
    check({tag, "_level"},     link.tx_level, 0);
    check({tag, "_ready"},     link.tx_ready, 1);
  endtask

  initial begin
    bit seen;
    int rxv0;
    link.en = 1'b0; link.tx_data = '0; link.tx_valid = 1'b0; link.clr_underrun = 1'b0;
    #2 rst_n = 1'b0;
    #10 check_reset_outputs("reset");
    @(posedge ck); #1 rst_n = 1'b1;

    // Disabled link keeps ssp_clk static.
    seen = 1'b0;
    repeat (20) begin
      @(negedge ck);
      if (link.ssp_clk) seen = 1'b1;
    end
    check("sspclk_static_idle", seen, 0);

    push_one(8'hA5);
    link.tx_valid = 1'b0;
    run_words(1);

    push_one(8'h3C);
    push_one(8'hC3);
    link.tx_valid = 1'b0;
    run_words(2);
    check("rx_spacing", rx_t_last - rx_t_prev, W * DIV);

    // Empty FIFO: idle words, underrun set wins over a simultaneous clear.
    plan_words(2);
    tick();
    link.en = 1'b1;
    wait_frame();
    check("underrun_set", link.tx_underrun, 1);
    repeat (31) @(posedge ck);
    #1 link.clr_underrun = 1'b1;
    @(posedge ck);
    #1 link.clr_underrun = 1'b0;
    link.en = 1'b0;
    check("underrun_set_priority", link.tx_underrun, 1);
    wait_idle();
    clr_pulse();

    // Overfill: fifth push discarded, fifth frame carries the idle word.
    for (int i = 0; i < 5; i++) push_one(8'h11 * 8'(i + 1));
    link.tx_valid = 1'b0;
    run_words(5);
    clr_pulse();

    for (int r = 0; r < 6; r++) begin
      int n = $urandom_range(0, 5);
      for (int i = 0; i < n; i++) push_one(8'($urandom));
      link.tx_valid = 1'b0;
      run_words($urandom_range(1, 6));
      if ($urandom_range(0, 1) == 1) clr_pulse();
    end

    // Reset during bit 5 abandons the word.
    while (model.size() > 0) void'(model.pop_front());
    push_one(8'h5A);
    link.tx_valid = 1'b0;
    void'(model.pop_front());
    tick();
    link.en = 1'b1;
    wait_frame();
    repeat (22) @(posedge ck);
    rxv0 = n_rxv;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midword_reset");
    link.en = 1'b0;
    exp_under = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (40) tick();
    check("no_rx_after_reset", n_rxv, rxv0);
    check("idle_after_reset", link.ssp_clk, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
